operand_shifter_pipe: RTL and testbench

// Pipelined, parametrised operand-2 barrel shifter for the ARM datapath; sits between

---
 rtl/operand_shifter_pipe.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_operand_shifter_pipe.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_shifter_pipe.sv
// ARM operand-2 barrel shifter. The decode step reduces every mode to one
// (operand, shift type, amount, carry) tuple, so the shift step is a single barrel.
module operand_shifter_pipe #(
    parameter int WIDTH       = 32,
    parameter int PIPE_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [1:0]       shift_type,
    input  logic [7:0]       shift_amt,
    input  logic [WIDTH-1:0] rm_data,
    input  logic [11:0]      imm12,
    input  logic [23:0]      branch_offset,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] shifted_data,
    output logic             carry_out,
    output logic             busy
);
    localparam int            AW      = $clog2(WIDTH);
    localparam logic [AW-1:0] AMT_TOP = AW'(WIDTH - 1);
    localparam logic [AW-1:0] AMT_ONE = AW'(1);
    localparam logic [AW-1:0] AMT_TWO = AW'(2);
    localparam logic [AW:0]   WIDTH_A = (AW+1)'(WIDTH);
    localparam logic [31:0]   WIDTH_U = 32'(WIDTH);

    typedef enum logic [1:0] {
        MD_IMM    = 2'b00,
        MD_REG    = 2'b01,
        MD_ROTIMM = 2'b10,
        MD_BRANCH = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_e;

    // Amounts are always < WIDTH here; rotate uses (x >> a) | (x << (W - a)),
    // where a shift by exactly W yields 0 and leaves a == 0 as a pass-through.
    function automatic logic [WIDTH-1:0] barrel(
        input logic [WIDTH-1:0] x,
        input shift_e           t,
        input logic [AW-1:0]    a
    );
        logic [AW:0]             inv;
        logic signed [WIDTH-1:0] sx;
        inv = WIDTH_A - {1'b0, a};
        sx  = $signed(x) >>> a;
        case (t)
            SH_LSL:  barrel = x << a;
            SH_LSR:  barrel = x >> a;
            SH_ASR:  barrel = $unsigned(sx);
            default: barrel = (x >> a) | (x << inv);
        endcase
    endfunction

    logic [AW-1:0]           w_n5;
    logic [AW-1:0]           w_n5_neg;
    logic [AW-1:0]           w_n5_dec;
    logic [AW-1:0]           w_nr;
    logic [AW-1:0]           w_nr_neg;
    logic [AW-1:0]           w_nr_dec;
    logic [AW-1:0]           w_rot;
    logic [AW-1:0]           w_rot_dec;
    logic                    w_n_zero;
    logic                    w_n_lt_w;
    logic                    w_n_eq_w;
    logic [WIDTH-1:0]        w_imm_zx;
    logic signed [WIDTH-1:0] w_boff_sx;

    assign w_n5      = AW'(shift_amt[4:0]);
    assign w_n5_neg  = ~w_n5 + AMT_ONE;
    assign w_n5_dec  = w_n5 - AMT_ONE;
    assign w_nr      = AW'(shift_amt);
    assign w_nr_neg  = ~w_nr + AMT_ONE;
    assign w_nr_dec  = w_nr - AMT_ONE;
    assign w_rot     = AW'({imm12[11:8], 1'b0});
    assign w_rot_dec = w_rot - AMT_ONE;
    assign w_n_zero  = (shift_amt == 8'd0);
    assign w_n_lt_w  = ({24'd0, shift_amt} < WIDTH_U);
    assign w_n_eq_w  = ({24'd0, shift_amt} == WIDTH_U);
    assign w_imm_zx  = WIDTH'(imm12[7:0]);
    assign w_boff_sx = {{(WIDTH-24){branch_offset[23]}}, branch_offset};

    logic [WIDTH-1:0] w_dec_op;
    shift_e           w_dec_type;
    logic [AW-1:0]    w_dec_amt;
    logic             w_dec_c;

    // Carry is always a single operand bit (or carry_in), so it is resolved here
    // rather than extracted from the shifter.
    always_comb begin
        w_dec_op   = rm_data;
        w_dec_type = SH_LSL;
        w_dec_amt  = '0;
        w_dec_c    = carry_in;
        case (mode)
            MD_IMM: begin
                case (shift_type)
                    SH_LSL: begin
                        if (w_n5 != '0) begin
                            w_dec_amt = w_n5;
                            w_dec_c   = rm_data[w_n5_neg];
                        end
                    end
                    SH_LSR: begin
                        w_dec_type = SH_LSR;
                        if (w_n5 == '0) begin
                            w_dec_op = '0;
                            w_dec_c  = rm_data[WIDTH-1];
                        end else begin
                            w_dec_amt = w_n5;
                            w_dec_c   = rm_data[w_n5_dec];
                        end
                    end
                    SH_ASR: begin
                        w_dec_type = SH_ASR;
                        if (w_n5 == '0) begin
                            w_dec_amt = AMT_TOP;
                            w_dec_c   = rm_data[WIDTH-1];
                        end else begin
                            w_dec_amt = w_n5;
                            w_dec_c   = rm_data[w_n5_dec];
                        end
                    end
                    default: begin
                        w_dec_type = SH_ROR;
                        if (w_n5 == '0) begin
                            // RRX as a rotate-by-one with carry_in spliced into bit 0.
                            w_dec_op  = {rm_data[WIDTH-1:1], carry_in};
                            w_dec_amt = AMT_ONE;
                            w_dec_c   = rm_data[0];
                        end else begin
                            w_dec_amt = w_n5;
                            w_dec_c   = rm_data[w_n5_dec];
                        end
                    end
                endcase
            end
            MD_REG: begin
                if (!w_n_zero) begin
                    case (shift_type)
                        SH_LSL: begin
                            if (w_n_lt_w) begin
                                w_dec_amt = w_nr;
                                w_dec_c   = rm_data[w_nr_neg];
                            end else begin
                                w_dec_op = '0;
                                w_dec_c  = w_n_eq_w & rm_data[0];
                            end
                        end
                        SH_LSR: begin
                            if (w_n_lt_w) begin
                                w_dec_type = SH_LSR;
                                w_dec_amt  = w_nr;
                                w_dec_c    = rm_data[w_nr_dec];
                            end else begin
                                w_dec_op = '0;
                                w_dec_c  = w_n_eq_w & rm_data[WIDTH-1];
                            end
                        end
                        SH_ASR: begin
                            w_dec_type = SH_ASR;
                            if (w_n_lt_w) begin
                                w_dec_amt = w_nr;
                                w_dec_c   = rm_data[w_nr_dec];
                            end else begin
                                w_dec_amt = AMT_TOP;
                                w_dec_c   = rm_data[WIDTH-1];
                            end
                        end
                        default: begin
                            if (w_nr == '0) begin
                                w_dec_c = rm_data[WIDTH-1];
                            end else begin
                                w_dec_type = SH_ROR;
                                w_dec_amt  = w_nr;
                                w_dec_c    = rm_data[w_nr_dec];
                            end
                        end
                    endcase
                end
            end
            MD_ROTIMM: begin
                w_dec_op = w_imm_zx;
                if (imm12[11:8] != 4'd0) begin
                    w_dec_type = SH_ROR;
                    w_dec_amt  = w_rot;
                    w_dec_c    = w_imm_zx[w_rot_dec];
                end
            end
            default: begin
                w_dec_op  = $unsigned(w_boff_sx);
                w_dec_amt = AMT_TWO;
            end
        endcase
    end

    logic             w_ld_out;
    logic             w_src_vld;
    logic [WIDTH-1:0] w_sh_op;
    shift_e           w_sh_type;
    logic [AW-1:0]    w_sh_amt;
    logic             w_sh_c;
    logic             r_vld_p1;
    logic [WIDTH-1:0] r_data_p1;
    logic             r_carry_p1;

    assign w_ld_out = !r_vld_p1 || out_ready;

    generate
        if (PIPE_STAGES == 2) begin : g_decode_reg
            logic             r_vld_p0;
            logic [WIDTH-1:0] r_op_p0;
            shift_e           r_type_p0;
            logic [AW-1:0]    r_amt_p0;
            logic             r_c_p0;

            // ---- stage p0: decoded operation ----
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_vld_p0 <= 1'b0;
                end else if (in_ready) begin
                    r_vld_p0 <= in_valid;
                end
            end

            always_ff @(posedge clk) begin
                if (in_ready && in_valid) begin
                    r_op_p0   <= w_dec_op;
                    r_type_p0 <= w_dec_type;
                    r_amt_p0  <= w_dec_amt;
                    r_c_p0    <= w_dec_c;
                end
            end

            assign in_ready  = !r_vld_p0 || w_ld_out;
            assign w_src_vld = r_vld_p0;
            assign w_sh_op   = r_op_p0;
            assign w_sh_type = r_type_p0;
            assign w_sh_amt  = r_amt_p0;
            assign w_sh_c    = r_c_p0;
            assign busy      = r_vld_p0 || r_vld_p1;
        end else begin : g_decode_comb
            assign in_ready  = w_ld_out;
            assign w_src_vld = in_valid;
            assign w_sh_op   = w_dec_op;
            assign w_sh_type = w_dec_type;
            assign w_sh_amt  = w_dec_amt;
            assign w_sh_c    = w_dec_c;
            assign busy      = r_vld_p1;
        end
    endgenerate

    // ---- stage p1: shift result, held while the consumer stalls ----
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld_p1   <= 1'b0;
            r_data_p1  <= '0;
            r_carry_p1 <= 1'b0;
        end else if (w_ld_out) begin
            r_vld_p1 <= w_src_vld;
            if (w_src_vld) begin
                r_data_p1  <= barrel(w_sh_op, w_sh_type, w_sh_amt);
                r_carry_p1 <= w_sh_c;
            end
        end
    end

    assign out_valid    = r_vld_p1;
    assign shifted_data = r_data_p1;
    assign carry_out    = r_carry_p1;

endmodule

// File: tb/tb_operand_shifter_pipe.sv
// Scoreboard bench for operand_shifter_pipe: a driver pushes expected results on
// accept, a monitor pops and compares on every retire.
`timescale 1ns/1ps
module tb_operand_shifter_pipe;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   mode;
    logic [1:0]   shift_type;
    logic [7:0]   shift_amt;
    logic [W-1:0] rm_data;
    logic [11:0]  imm12;
    logic [23:0]  branch_offset;
    logic         carry_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] shifted_data;
    logic         carry_out;
    logic         busy;

    always #5 clk = ~clk;

    operand_shifter_pipe #(.WIDTH(W), .PIPE_STAGES(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .shift_type(shift_type), .shift_amt(shift_amt),
        .rm_data(rm_data), .imm12(imm12), .branch_offset(branch_offset),
        .carry_in(carry_in), .out_valid(out_valid), .out_ready(out_ready),
        .shifted_data(shifted_data), .carry_out(carry_out), .busy(busy)
    );

    typedef struct packed {
        logic         c;
        logic [W-1:0] d;
    } exp_t;

    exp_t sb[$];
    int   n_checks  = 0;
    int   n_pass    = 0;
    int   n_retired = 0;
    bit   rdy_rand  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Reference: ARM operand-2 rules evaluated with 64-bit windows, where the
    // carry is simply the bit that falls just outside the kept 32-bit slice.
    function automatic logic [W:0] ref_model(input logic [1:0] md, input logic [1:0] ty,
                                             input logic [7:0] amt, input logic [31:0] rm,
                                             input logic [11:0] imm, input logic [23:0] off,
                                             input logic cin);
        logic [63:0] t;
        logic [31:0] r;
        logic [31:0] v;
        logic        c;
        int          n;
        int          k;
        r = rm;
        c = cin;
        case (md)
            2'b00: begin
                n = int'(amt[4:0]);
                case (ty)
                    2'b00: if (n != 0) begin t = {32'd0, rm} << n; r = t[31:0]; c = t[32]; end
                    2'b01: begin if (n == 0) n = 32; t = {rm, 32'd0} >> n; r = t[63:32]; c = t[31]; end
                    2'b10: begin if (n == 0) n = 32; t = $signed({rm, 32'd0}) >>> n; r = t[63:32]; c = t[31]; end
                    default: begin
                        if (n == 0) begin r = {cin, rm[31:1]}; c = rm[0]; end
                        else begin r = (rm >> n) | (rm << (32 - n)); c = r[31]; end
                    end
                endcase
            end
            2'b01: begin
                n = int'(amt);
                if (n != 0) begin
                    case (ty)
                        2'b00: if (n <= 32) begin t = {32'd0, rm} << n; r = t[31:0]; c = t[32]; end
                               else begin r = 0; c = 0; end
                        2'b01: if (n <= 32) begin t = {rm, 32'd0} >> n; r = t[63:32]; c = t[31]; end
                               else begin r = 0; c = 0; end
                        2'b10: begin if (n > 32) n = 32; t = $signed({rm, 32'd0}) >>> n; r = t[63:32]; c = t[31]; end
                        default: begin
                            k = n % 32;
                            if (k == 0) begin r = rm; c = rm[31]; end
                            else begin r = (rm >> k) | (rm << (32 - k)); c = r[31]; end
                        end
                    endcase
                end
            end
            2'b10: begin
                k = 2 * int'(imm[11:8]);
                v = {24'd0, imm[7:0]};
                if (k == 0) begin r = v; c = cin; end
                else begin r = (v >> k) | (v << (32 - k)); c = r[31]; end
            end
            default: begin
                r = {{8{off[23]}}, off} << 2;
                c = cin;
            end
        endcase
        return {c, r};
    endfunction

    // Called at a falling edge; returns at the falling edge after the accept.
    task automatic send(input logic [1:0] md, input logic [1:0] ty, input logic [7:0] amt,
                        input logic [31:0] rm, input logic [11:0] imm, input logic [23:0] off,
                        input logic cin, input bit use_exp, input logic [W:0] exp_v);
        int   waited;
        exp_t e;
        mode = md; shift_type = ty; shift_amt = amt; rm_data = rm;
        imm12 = imm; branch_offset = off; carry_in = cin; in_valid = 1'b1;
        #1;
        waited = 0;
        while (!in_ready && waited < 200) begin
            @(negedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            n_checks++;
            $display("FAIL accept_timeout: in_ready=0 after %0d cycles, expected 1", waited);
            in_valid = 1'b0;
            return;
        end
        e = use_exp ? exp_v : ref_model(md, ty, amt, rm, imm, off, cin);
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic send_rand();
        logic [1:0] md;
        logic [7:0] amt;
        logic [31:0] rm;
        md  = 2'($urandom_range(0, 3));
        amt = 8'($urandom);
        if (md == 2'b01) begin
            case ($urandom_range(0, 7))
                0: amt = 8'd0;
                1: amt = 8'd32;
                2: amt = 8'd33;
                3: amt = 8'd31;
                4: amt = 8'd64;
                5: amt = 8'd1;
                default: ;
            endcase
        end
        rm = ($urandom_range(0, 5) == 0) ? 32'h8000_0001 : $urandom;
        send(md, 2'($urandom_range(0, 3)), amt, rm, 12'($urandom), 24'($urandom),
             1'($urandom), 1'b0, '0);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((sb.size() != 0 || busy) && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk(name, 64'(sb.size()), 64'd0);
    endtask

    initial begin : ready_gen
        forever begin
            @(negedge clk);
            if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin : monitor
        logic       prev_stall;
        logic [W:0] held;
        exp_t       e;
        prev_stall = 1'b0;
        held       = '0;
        forever begin
            @(negedge clk); #2;
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", 64'(out_valid), 64'd1);
                    chk("hold_value", 64'({carry_out, shifted_data}), 64'(held));
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_output: got %h, expected no output", {carry_out, shifted_data});
                    end else begin
                        e = sb.pop_front();
                        chk("result", 64'({carry_out, shifted_data}), 64'(e));
                        n_retired++;
                    end
                end
                prev_stall = out_valid && !out_ready;
                held       = {carry_out, shifted_data};
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int base;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        mode = '0; shift_type = '0; shift_amt = '0; rm_data = '0;
        imm12 = '0; branch_offset = '0; carry_in = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_data", 64'(shifted_data), 64'd0);
        chk("rst_carry", 64'(carry_out), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        // Directed boundary vectors with hand-derived results.
        send(2'b00, 2'b01, 8'd0,  32'h8000_0001, '0, '0, 1'b0, 1'b1, {1'b1, 32'h0000_0000});
        send(2'b00, 2'b10, 8'd0,  32'h8000_0001, '0, '0, 1'b0, 1'b1, {1'b1, 32'hFFFF_FFFF});
        send(2'b00, 2'b11, 8'd0,  32'h0000_0003, '0, '0, 1'b1, 1'b1, {1'b1, 32'h8000_0001});
        send(2'b00, 2'b00, 8'd4,  32'hF000_000F, '0, '0, 1'b0, 1'b1, {1'b1, 32'h0000_00F0});
        send(2'b01, 2'b00, 8'd32, 32'h0000_0001, '0, '0, 1'b0, 1'b1, {1'b1, 32'h0000_0000});
        send(2'b01, 2'b00, 8'd33, 32'h0000_0001, '0, '0, 1'b1, 1'b1, {1'b0, 32'h0000_0000});
        send(2'b01, 2'b00, 8'd0,  32'h1234_5678, '0, '0, 1'b1, 1'b1, {1'b1, 32'h1234_5678});
        send(2'b01, 2'b01, 8'd32, 32'h8000_0000, '0, '0, 1'b0, 1'b1, {1'b1, 32'h0000_0000});
        send(2'b01, 2'b10, 8'd200, 32'h8000_0000, '0, '0, 1'b0, 1'b1, {1'b1, 32'hFFFF_FFFF});
        send(2'b01, 2'b11, 8'd64, 32'h8000_0000, '0, '0, 1'b0, 1'b1, {1'b1, 32'h8000_0000});
        send(2'b10, 2'b00, 8'd0,  32'h0, 12'h4FF, '0, 1'b0, 1'b1, {1'b1, 32'hFF00_0000});
        send(2'b10, 2'b00, 8'd0,  32'h0, 12'h0FF, '0, 1'b0, 1'b1, {1'b0, 32'h0000_00FF});
        send(2'b11, 2'b00, 8'd0,  32'h0, '0, 24'hFFFFFE, 1'b1, 1'b1, {1'b1, 32'hFFFF_FFF8});
        send(2'b11, 2'b00, 8'd0,  32'h0, '0, 24'h000003, 1'b0, 1'b1, {1'b0, 32'h0000_000C});
        in_valid = 1'b0;
        drain("directed_drain");

        // Unstalled latency of exactly two cycles.
        @(negedge clk);
        send_rand();
        in_valid = 1'b0;
        #1;
        chk("latency_early", 64'(out_valid), 64'd0);
        @(negedge clk); #1;
        chk("latency_exact", 64'(out_valid), 64'd1);
        @(negedge clk);
        drain("latency_drain");

        // Backpressure: four back-to-back requests, output stalled three cycles.
        base = n_retired;
        @(negedge clk);
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) send_rand();
                in_valid = 1'b0;
            end
            begin
                int k;
                k = 0;
                while (!out_valid && k < 50) begin @(negedge clk); k++; end
                repeat (3) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain("bp_drain");
        chk("bp_retired", 64'(n_retired - base), 64'd4);

        // Reset with two entries in flight.
        @(negedge clk);
        out_ready = 1'b0;
        send_rand();
        send_rand();
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        base = n_retired;
        #1;
        chk("rif_out_valid", 64'(out_valid), 64'd0);
        chk("rif_busy", 64'(busy), 64'd0);
        chk("rif_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        chk("rif_no_stale", 64'(n_retired - base), 64'd0);

        // Randomised traffic with random consumer stalls.
        rdy_rand = 1'b1;
        for (int i = 0; i < 400; i++) begin
            send_rand();
            if ($urandom_range(0, 4) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        in_valid = 1'b0;
        rdy_rand = 1'b0;
        out_ready = 1'b1;
        drain("random_drain");
        chk("final_busy", 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
